// File: rtl/store_buffer.sv
// Store buffer: formats committed stores into word address/strobes/lane data and drains them to the SRAM write port.
// Latency: a push at edge t raises dreq_o in cycle t+1 when the buffer was empty; lookup outputs are zero-latency.
// Backpressure: stb_stall_o while full (same-cycle pop not credited); one outstanding write, gated by daddr_ok_i/ddata_ok_i.
// Optional feature macro: STB_LOAD_FWD_EN (forward full-word matches to loads instead of stalling them).

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid_i,
  input  logic [11:0] st_memop_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic        flush_i,
  output logic        stb_stall_o,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_conflict_o,
  output logic        ld_fwd_valid_o,
  output logic [31:0] ld_fwd_data_o,
  output logic        dreq_o,
  output logic [31:0] daddr_o,
  output logic [3:0]  dwstrb_o,
  output logic [31:0] dwdata_o,
  input  logic        daddr_ok_i,
  input  logic        ddata_ok_i,
  output logic        stb_empty_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]   head_q, tail_q;
  logic [PW:0]   count;
  logic [PW-1:0] head_idx, tail_idx;
  logic [29:0]   ent_addr [DEPTH];
  logic [3:0]    ent_strb [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  state_t        state_q, state_d;
  logic          full, empty, is_store, push, pop;
  logic [3:0]    fmt_strb;
  logic [31:0]   fmt_data;
  logic [1:0]    a;
  logic          hit;
  logic [PW-1:0] hit_idx, scan_idx;
  logic          unused_bits;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);
  assign is_store = st_memop_i[5] | st_memop_i[6] | st_memop_i[7] | st_memop_i[10] | st_memop_i[11];
  assign push     = st_valid_i & ~flush_i & ~full & is_store;
  assign a        = st_addr_i[1:0];

  assign stb_stall_o = full;
  assign stb_empty_o = empty;

  // Bits that carry no meaning for stores or word lookups.
  assign unused_bits = ^{st_memop_i[11:10] & 2'b00, st_memop_i[9:8], st_memop_i[4:0], ld_addr_i[1:0]};

  // Store formatting: byte enables and lane-shifted data for each store flavour.
  always_comb begin
    fmt_strb = 4'b0000;
    fmt_data = 32'h0;
    if (st_memop_i[5]) begin
      fmt_strb = 4'b0001 << a;
      fmt_data = {4{st_data_i[7:0]}};
    end else if (st_memop_i[6]) begin
      fmt_strb = a[1] ? 4'b1100 : 4'b0011;
      fmt_data = {2{st_data_i[15:0]}};
    end else if (st_memop_i[7]) begin
      fmt_strb = 4'b1111;
      fmt_data = st_data_i;
    end else if (st_memop_i[10]) begin
      case (a)
        2'd0:    begin fmt_strb = 4'b0001; fmt_data = {24'b0, st_data_i[31:24]}; end
        2'd1:    begin fmt_strb = 4'b0011; fmt_data = {16'b0, st_data_i[31:16]}; end
        2'd2:    begin fmt_strb = 4'b0111; fmt_data = {8'b0,  st_data_i[31:8]};  end
        default: begin fmt_strb = 4'b1111; fmt_data = st_data_i;                 end
      endcase
    end else if (st_memop_i[11]) begin
      case (a)
        2'd0:    begin fmt_strb = 4'b1111; fmt_data = st_data_i;                 end
        2'd1:    begin fmt_strb = 4'b1110; fmt_data = {st_data_i[23:0], 8'b0};  end
        2'd2:    begin fmt_strb = 4'b1100; fmt_data = {st_data_i[15:0], 16'b0}; end
        default: begin fmt_strb = 4'b1000; fmt_data = {st_data_i[7:0], 24'b0};  end
      endcase
    end
  end

  // Entry storage: payload only, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail_idx] <= st_addr_i[31:2];
      ent_strb[tail_idx] <= fmt_strb;
      ent_data[tail_idx] <= fmt_data;
    end
  end

  // Head/tail pointer update; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Drain FSM state register; reset abandons any outstanding write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Drain FSM next state: request the head, then wait for write completion.
  always_comb begin
    state_d = state_q;
    dreq_o  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        dreq_o = ~empty;
        if (~empty & daddr_ok_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ddata_ok_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request payload is the head entry while requesting, zero otherwise.
  always_comb begin
    daddr_o  = 32'h0;
    dwstrb_o = 4'b0000;
    dwdata_o = 32'h0;
    if (dreq_o) begin
      daddr_o  = {ent_addr[head_idx], 2'b00};
      dwstrb_o = ent_strb[head_idx];
      dwdata_o = ent_data[head_idx];
    end
  end

  // Load lookup: scan oldest to youngest so the last match is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + PW'(k);
      if (((PW+1)'(k) < count) && (ent_addr[scan_idx] == ld_addr_i[31:2])) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

`ifdef STB_LOAD_FWD_EN
  logic fwd_hit;
  assign fwd_hit        = ld_valid_i & hit & (ent_strb[hit_idx] == 4'b1111);
  assign ld_fwd_valid_o = fwd_hit;
  assign ld_fwd_data_o  = fwd_hit ? ent_data[hit_idx] : 32'h0;
  assign ld_conflict_o  = ld_valid_i & hit & ~fwd_hit;
`else
  logic [PW-1:0] unused_hit_idx;
  assign unused_hit_idx = hit_idx;
  assign ld_fwd_valid_o = 1'b0;
  assign ld_fwd_data_o  = 32'h0;
  assign ld_conflict_o  = ld_valid_i & hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [11:0] OP_SB  = 12'h020;
  localparam logic [11:0] OP_SH  = 12'h040;
  localparam logic [11:0] OP_SW  = 12'h080;
  localparam logic [11:0] OP_SWL = 12'h400;
  localparam logic [11:0] OP_SWR = 12'h800;
  localparam logic [11:0] OPS [6] = '{OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, 12'h001};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid_i, flush_i, ld_valid_i, daddr_ok_i, ddata_ok_i;
  logic [11:0] st_memop_i;
  logic [31:0] st_addr_i, st_data_i, ld_addr_i;
  logic        stb_stall_o, ld_conflict_o, ld_fwd_valid_o, dreq_o, stb_empty_o;
  logic [31:0] ld_fwd_data_o, daddr_o, dwdata_o;
  logic [3:0]  dwstrb_o;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid_i(st_valid_i), .st_memop_i(st_memop_i), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .flush_i(flush_i), .stb_stall_o(stb_stall_o),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_conflict_o(ld_conflict_o),
    .ld_fwd_valid_o(ld_fwd_valid_o), .ld_fwd_data_o(ld_fwd_data_o),
    .dreq_o(dreq_o), .daddr_o(daddr_o), .dwstrb_o(dwstrb_o), .dwdata_o(dwdata_o),
    .daddr_ok_i(daddr_ok_i), .ddata_ok_i(ddata_ok_i), .stb_empty_o(stb_empty_o)
  );

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_wait;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic bit is_store(logic [11:0] op);
    return op[5] | op[6] | op[7] | op[10] | op[11];
  endfunction

  // Reference formatting from the byte-lane rules, written arithmetically.
  function automatic ent_t fmt(logic [11:0] op, logic [31:0] addr, logic [31:0] d);
    ent_t e;
    int o;
    o = int'(addr[1:0]);
    e.wa = addr[31:2];
    if (op[5]) begin
      e.strb = 4'(1 << o);
      e.data = {24'b0, d[7:0]} * 32'h0101_0101;
    end else if (op[6]) begin
      e.strb = (o >= 2) ? 4'b1100 : 4'b0011;
      e.data = {16'b0, d[15:0]} * 32'h0001_0001;
    end else if (op[7]) begin
      e.strb = 4'b1111;
      e.data = d;
    end else if (op[10]) begin
      e.strb = 4'((1 << (o + 1)) - 1);
      e.data = d >> (8 * (3 - o));
    end else begin
      e.strb = 4'(15 << o);
      e.data = d << (8 * o);
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    st_valid_i = 0; st_memop_i = 0; st_addr_i = 0; st_data_i = 0; flush_i = 0;
    ld_valid_i = 0; ld_addr_i = 0; daddr_ok_i = 0; ddata_ok_i = 0;
  endtask

  // Check every output against the model, advance the model, then move to the next negedge.
  task automatic cycle();
    bit          e_dreq, hit, e_conf, e_fv, full;
    logic [31:0] e_addr, e_data, e_fd;
    logic [3:0]  e_strb;
    ent_t        h;
    #1;
    e_dreq = !m_wait && (q.size() != 0);
    e_addr = 0; e_strb = 0; e_data = 0;
    if (e_dreq) begin
      e_addr = {q[0].wa, 2'b00};
      e_strb = q[0].strb;
      e_data = q[0].data;
    end
    chk("dreq", 32'(dreq_o), 32'(e_dreq));
    chk("daddr", daddr_o, e_addr);
    chk("dwstrb", 32'(dwstrb_o), 32'(e_strb));
    chk("dwdata", dwdata_o, e_data);
    chk("stall", 32'(stb_stall_o), 32'(q.size() == DEPTH));
    chk("empty", 32'(stb_empty_o), 32'(q.size() == 0));
    hit = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wa == ld_addr_i[31:2]) begin
        hit = 1;
        h = q[i];
        break;
      end
    end
    e_conf = 0; e_fv = 0; e_fd = 0;
    if (ld_valid_i && hit) begin
`ifdef STB_LOAD_FWD_EN
      if (h.strb == 4'b1111) begin
        e_fv = 1;
        e_fd = h.data;
      end else e_conf = 1;
`else
      e_conf = 1;
`endif
    end
    chk("ld_conflict", 32'(ld_conflict_o), 32'(e_conf));
    chk("ld_fwd_valid", 32'(ld_fwd_valid_o), 32'(e_fv));
    chk("ld_fwd_data", ld_fwd_data_o, e_fd);
    full = (q.size() == DEPTH);
    if (m_wait && ddata_ok_i) begin
      void'(q.pop_front());
      m_wait = 0;
    end else if (!m_wait && e_dreq && daddr_ok_i) begin
      m_wait = 1;
    end
    if (st_valid_i && !flush_i && !full && is_store(st_memop_i))
      q.push_back(fmt(st_memop_i, st_addr_i, st_data_i));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(logic [11:0] op, logic [31:0] addr, logic [31:0] data);
    st_valid_i = 1; st_memop_i = op; st_addr_i = addr; st_data_i = data;
    cycle();
    st_valid_i = 0;
  endtask

  task automatic drain_one(int addr_wait, int data_wait);
    for (int i = 0; i < addr_wait; i++) cycle();
    daddr_ok_i = 1; cycle(); daddr_ok_i = 0;
    for (int i = 0; i < data_wait; i++) cycle();
    ddata_ok_i = 1; cycle(); ddata_ok_i = 0;
  endtask

  initial begin
    zero_inputs();
    m_wait = 0;
    rst_n  = 0;
    @(negedge clk); @(negedge clk);
    // Reset state
    chk("rst_empty", 32'(stb_empty_o), 32'd1);
    chk("rst_dreq", 32'(dreq_o), 32'd0);
    chk("rst_stall", 32'(stb_stall_o), 32'd0);
    chk("rst_daddr", daddr_o, 32'd0);
    rst_n = 1;
    cycle();

    // Formatting: sb, swl a=1, swr a=2
    push(OP_SB, 32'h1003, 32'h0000_00AB);
    #1;
    chk("sb_daddr", daddr_o, 32'h1000);
    chk("sb_strb", 32'(dwstrb_o), 32'h8);
    chk("sb_data", dwdata_o, 32'hABAB_ABAB);
    drain_one(0, 0);
    push(OP_SWL, 32'h1001, 32'hA1B2_C3D4);
    #1;
    chk("swl_strb", 32'(dwstrb_o), 32'h3);
    chk("swl_data", dwdata_o, 32'h0000_A1B2);
    drain_one(0, 0);
    push(OP_SWR, 32'h1002, 32'hA1B2_C3D4);
    #1;
    chk("swr_strb", 32'(dwstrb_o), 32'hC);
    chk("swr_data", dwdata_o, 32'hC3D4_0000);
    drain_one(0, 0);

    // Handshake: accept delayed 3 cycles, completion 2 cycles after accept
    push(OP_SW, 32'h2000, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hs_hold_req", 32'(dreq_o), 32'd1);
      chk("hs_hold_addr", daddr_o, 32'h2000);
      chk("hs_hold_data", dwdata_o, 32'h1234_5678);
      cycle();
    end
    daddr_ok_i = 1; cycle(); daddr_ok_i = 0;
    #1; chk("hs_wait_req", 32'(dreq_o), 32'd0);
    cycle();
    ddata_ok_i = 1; cycle(); ddata_ok_i = 0;
    #1; chk("hs_empty_after_pop", 32'(stb_empty_o), 32'd1);
    cycle();

    // Full: four stores fill the buffer, the fifth waits for a pop
    for (int i = 0; i < 4; i++) push(OP_SW, 32'h5000 + 32'(i * 4), 32'h100 + 32'(i));
    #1; chk("full_stall", 32'(stb_stall_o), 32'd1);
    st_valid_i = 1; st_memop_i = OP_SW; st_addr_i = 32'h5010; st_data_i = 32'h104;
    cycle();
    daddr_ok_i = 1; cycle(); daddr_ok_i = 0;
    ddata_ok_i = 1; cycle(); ddata_ok_i = 0;
    #1; chk("full_stall_clear", 32'(stb_stall_o), 32'd0);
    cycle();
    st_valid_i = 0;
    #1; chk("full_refill", 32'(stb_stall_o), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      #1; chk("wrap_order", daddr_o, 32'h5000 + 32'(i * 4));
      drain_one(0, 0);
    end
    #1; chk("wrap_empty", 32'(stb_empty_o), 32'd1);

    // Flush kills the store
    st_valid_i = 1; st_memop_i = OP_SW; st_addr_i = 32'h6000; flush_i = 1;
    cycle();
    st_valid_i = 0; flush_i = 0;
    #1;
    chk("flush_empty", 32'(stb_empty_o), 32'd1);
    chk("flush_dreq", 32'(dreq_o), 32'd0);
    cycle();

    // Lookup
    push(OP_SW, 32'h3000, 32'hDEAD_BEEF);
    ld_valid_i = 1; ld_addr_i = 32'h3000;
    #1;
`ifdef STB_LOAD_FWD_EN
    chk("lk_fwd_valid", 32'(ld_fwd_valid_o), 32'd1);
    chk("lk_fwd_data", ld_fwd_data_o, 32'hDEAD_BEEF);
    chk("lk_fwd_noconf", 32'(ld_conflict_o), 32'd0);
`else
    chk("lk_sw_conf", 32'(ld_conflict_o), 32'd1);
    chk("lk_sw_nofwd", 32'(ld_fwd_valid_o), 32'd0);
`endif
    push(OP_SB, 32'h3001, 32'h0000_0055);
    #1;
    chk("lk_sb_conf", 32'(ld_conflict_o), 32'd1);
    chk("lk_sb_nofwd", 32'(ld_fwd_valid_o), 32'd0);
    ld_addr_i = 32'h4000;
    #1;
    chk("lk_miss_conf", 32'(ld_conflict_o), 32'd0);
    cycle();
    ld_valid_i = 0;
    drain_one(1, 0);
    drain_one(0, 1);

    // Reset during WAIT with a stray completion afterwards
    push(OP_SW, 32'h7000, 32'h0BAD_F00D);
    daddr_ok_i = 1; cycle(); daddr_ok_i = 0;
    push(OP_SH, 32'h7006, 32'h0000_1234);
    #2;
    rst_n = 0;
    #1;
    chk("arst_dreq", 32'(dreq_o), 32'd0);
    chk("arst_daddr", daddr_o, 32'd0);
    chk("arst_data", dwdata_o, 32'd0);
    chk("arst_strb", 32'(dwstrb_o), 32'd0);
    chk("arst_empty", 32'(stb_empty_o), 32'd1);
    q.delete();
    m_wait = 0;
    @(negedge clk);
    ddata_ok_i = 1;
    @(negedge clk);
    rst_n = 1;
    cycle();
    ddata_ok_i = 0;
    #1; chk("arst_stray_empty", 32'(stb_empty_o), 32'd1);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      st_valid_i = ($urandom % 2) == 0;
      st_memop_i = OPS[$urandom_range(0, 5)];
      st_addr_i  = 32'h100 + 32'($urandom_range(0, 15));
      st_data_i  = $urandom;
      flush_i    = ($urandom % 8) == 0;
      ld_valid_i = ($urandom % 2) == 0;
      ld_addr_i  = 32'h100 + 32'($urandom_range(0, 19));
      daddr_ok_i = !m_wait && (($urandom % 3) == 0);
      ddata_ok_i = m_wait ? (($urandom % 3) == 0) : (!daddr_ok_i && (($urandom % 8) == 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
